// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit driving the ALU system control inputs.
// Optional illegal-opcode trap enabled by defining CU_ILLEGAL_TRAP_EN.
module control_sequencer #(
    parameter int ZFLAG_BIT = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IRIn,
    input  logic [3:0]  FlagsIn,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic        Halted,
    output logic        Illegal
);

    // state   | meaning
    // FETCH0  | read low instruction byte at PC, PC++
    // FETCH1  | read high instruction byte at PC, PC++
    // EXEC    | decode IR and issue one cycle of control
    // HALT    | absorbing stop state, left only by Reset
    typedef enum logic [1:0] {
        S_FETCH0 = 2'd0,
        S_FETCH1 = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  opcode;
    logic        zflag;
    logic        branch;
    logic        alu_op;
    logic        unused_inputs;

    assign opcode        = IRIn[15:10];
    assign zflag         = FlagsIn[ZFLAG_BIT];
    assign unused_inputs = ^{IRIn[3:0], FlagsIn};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_FETCH0;
        end else begin
            state <= state_next;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_set;

    // Sticky until Reset so software/debug can see why the core stopped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else if (illegal_set) begin
            illegal_q <= 1'b1;
        end
    end

    assign Illegal = illegal_q & ~Reset;
`else
    assign Illegal = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 2'b00;
        MuxDSel     = 1'b0;
        DR_E        = 1'b0;
        DR_FunSel   = 2'b00;
        Halted      = 1'b0;
        branch      = 1'b0;
        alu_op      = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif

        // Reset forces idle outputs so an abandoned fetch/exec writes nothing.
        if (!Reset) begin
            case (state)
                S_FETCH0, S_FETCH1: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (state == S_FETCH1);
                    ARF_RegSel  = 3'b100;
                    ARF_FunSel  = 2'b01;
                    state_next  = (state == S_FETCH0) ? S_FETCH1 : S_EXEC;
                end
                S_EXEC: begin
                    state_next = S_FETCH0;
                    case (opcode)
                        6'h00: ;
                        6'h01: branch = 1'b1;
                        6'h02: branch = ~zflag;
                        6'h03: branch = zflag;
                        6'h04: begin
                            MuxASel   = 2'b11;
                            RF_FunSel = 3'b010;
                            RF_RegSel = 4'b1000 >> IRIn[9:8];
                        end
                        6'h05: begin alu_op = 1'b1; ALU_FunSel = 5'b10100; end
                        6'h06: begin alu_op = 1'b1; ALU_FunSel = 5'b10110; end
                        6'h07: begin alu_op = 1'b1; ALU_FunSel = 5'b10111; end
                        6'h08: begin alu_op = 1'b1; ALU_FunSel = 5'b11000; end
                        6'h09: begin alu_op = 1'b1; ALU_FunSel = 5'b11001; end
                        6'h0A: state_next = S_HALT;
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            state_next  = S_HALT;
                            illegal_set = 1'b1;
`endif
                        end
                    endcase
                    if (branch) begin
                        MuxBSel    = 2'b11;
                        ARF_RegSel = 3'b100;
                        ARF_FunSel = 2'b10;
                    end
                    if (alu_op) begin
                        RF_OutASel = {1'b0, IRIn[7:6]};
                        RF_OutBSel = {1'b0, IRIn[5:4]};
                        MuxASel    = 2'b00;
                        RF_FunSel  = 3'b010;
                        RF_RegSel  = 4'b1000 >> IRIn[9:8];
                        ALU_WF     = 1'b1;
                    end
                end
                S_HALT: Halted = 1'b1;
                default: state_next = S_FETCH0;
            endcase
        end
    end

endmodule
